// File: rtl/vunit_pkg.sv
// -----------------------------------------------------------------------------
// vunit_pkg
//   Shared definitions for the vector unit register bank.
//   - log2 / bitwidth : constant helpers for sizing counters and length fields
//   - elem_t          : element word {valid, payload} at the default widths
//   - wr_state_e      : write-side FSM states of a vector register
//   - rd_state_e      : per-read-port FSM states of a vector register
// -----------------------------------------------------------------------------
package vunit_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int VALID_BITS     = 1;
  localparam int ELEM_WIDTH     = DATA_WIDTH_DEF + VALID_BITS;
  localparam int MVL_DEF        = 16;

  // Ceiling log2, never below 1 so it can size an index for a single entry.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Number of bits needed to hold the value n itself (e.g. 16 -> 5).
  function automatic int bitwidth(input int n);
    int r;
    r = 1;
    while ((n >> r) != 0) r++;
    return r;
  endfunction

  // Element word as it travels on the bank buses: valid flag in the MSB.
  typedef logic [ELEM_WIDTH-1:0] elem_t;

  typedef enum logic {
    WR_IDLE,
    WR_WRITING
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_READING
  } rd_state_e;

endpackage

// File: rtl/vreg_read_port.sv
// -----------------------------------------------------------------------------
// vreg_read_port
//   One read port of a vector register: IDLE/READING FSM, element index
//   counter and the registered output word.
//
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   one-cycle start pulse (ignored while READING)
//   len_i    in   clamped vector length, sampled on start; 0 = no-op
//   avail_i  in   element at idx_o may be emitted this edge
//   elem_i   in   stored payload at idx_o
//   idx_o    out  index of the next element to emit
//   data_o   out  {valid, payload}; valid drops on bubbles and after the last
//   busy_o   out  port is streaming
// -----------------------------------------------------------------------------
module vreg_read_port
  import vunit_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int MVL        = 16,
  localparam int LW         = bitwidth(MVL),
  localparam int IW         = log2(MVL),
  localparam int WIDTH      = DATA_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [LW-1:0]         len_i,
  input  logic                  avail_i,
  input  logic [DATA_WIDTH-1:0] elem_i,
  output logic [IW-1:0]         idx_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  busy_o
);

  rd_state_e        state_q, state_n;
  logic [IW-1:0]    idx_q, last_q;
  logic [WIDTH-1:0] data_q;
  logic             go, emit, done;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    go      = 1'b0;
    emit    = 1'b0;
    done    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start_i && (len_i != '0)) begin
          go      = 1'b1;
          state_n = RD_READING;
        end
      end
      RD_READING: begin
        if (avail_i) begin
          emit = 1'b1;
          if (idx_q == last_q) begin
            done    = 1'b1;
            state_n = RD_IDLE;
          end
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RD_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      if (go) begin
        idx_q  <= '0;
        last_q <= IW'(len_i - 1'b1);
      end
      if (emit) begin
        data_q <= {1'b1, elem_i};
        idx_q  <= idx_q + IW'(1);
      end else begin
        // Bubble or idle: only the valid flag drops, the payload holds.
        data_q[WIDTH-1] <= 1'b0;
      end
    end
  end

  // done is folded into state_n; kept as a named term for readability.
  logic unused_done;
  assign unused_done = done;

  assign idx_o  = idx_q;
  assign data_o = data_q;
  assign busy_o = (state_q == RD_READING);

endmodule

// File: rtl/vreg_bank.sv
// -----------------------------------------------------------------------------
// vreg_bank
//   One architectural vector register: MVL elements of DATA_WIDTH payload.
//   Responder end of the control unit's bank signalling: a single shared write
//   FSM (lowest-index start wins) and NUM_READ_PORTS independent read ports.
//
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset
//   vlr_i         in   vector length, clamped to MVL, sampled on any start
//   w_start_i     in   per-write-port start pulse
//   w_data_i      in   per-write-port element {valid, payload}; valid=0 is a bubble
//   w_busy_o      out  one-hot owning write port while writing
//   r_start_i     in   per-read-port start pulse
//   r_data_o      out  per-read-port element {valid, payload}
//   r_busy_o      out  per-read-port streaming flag
//   first_elem_o  out  element 0 of the current write has been stored
//
//   Build option VREG_CHAIN_EN: per-element valid flags are kept and readers
//   stall on unwritten elements (chaining). Without it every element is always
//   available and first_elem_o is tied low.
// -----------------------------------------------------------------------------
module vreg_bank
  import vunit_pkg::*;
#(
  parameter  int NUM_WRITE_PORTS = 2,
  parameter  int NUM_READ_PORTS  = 2,
  parameter  int DATA_WIDTH      = 32,
  parameter  int VALID           = 1,
  parameter  int WIDTH           = DATA_WIDTH + VALID,
  parameter  int MVL             = 16,
  localparam int LW              = bitwidth(MVL)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [LW-1:0]                     vlr_i,
  input  logic [NUM_WRITE_PORTS-1:0]        w_start_i,
  input  logic [NUM_WRITE_PORTS*WIDTH-1:0]  w_data_i,
  output logic [NUM_WRITE_PORTS-1:0]        w_busy_o,
  input  logic [NUM_READ_PORTS-1:0]         r_start_i,
  output logic [NUM_READ_PORTS*WIDTH-1:0]   r_data_o,
  output logic [NUM_READ_PORTS-1:0]         r_busy_o,
  output logic                              first_elem_o
);

  localparam int IW = log2(MVL);
  localparam int SW = log2(NUM_WRITE_PORTS);

  logic [LW-1:0]              len;
  logic [WIDTH-1:0]           w_elem [NUM_WRITE_PORTS];

  wr_state_e                  wr_state_q, wr_state_n;
  logic [SW-1:0]              wsel_q, wsel_n;
  logic [IW-1:0]              widx_q, wlast_q;
  logic [NUM_WRITE_PORTS-1:0] w_busy_q;
  logic                       wr_start, wr_store, wr_done;

  logic [DATA_WIDTH-1:0]      mem [MVL];
  logic [IW-1:0]              rd_idx [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0]  rd_avail;

  // Effective length shared by every start sampled this cycle.
  assign len = (vlr_i > LW'(MVL)) ? LW'(MVL) : vlr_i;

  for (genvar i = 0; i < NUM_WRITE_PORTS; i++) begin : g_wsplit
    assign w_elem[i] = w_data_i[i*WIDTH +: WIDTH];
  end

  // Lowest set start bit wins; scanning downward leaves the lowest last.
  always_comb begin
    wsel_n = '0;
    for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
      if (w_start_i[i]) wsel_n = SW'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_state_n = wr_state_q;
    wr_start   = 1'b0;
    wr_store   = 1'b0;
    wr_done    = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if ((|w_start_i) && (len != '0)) begin
          wr_start   = 1'b1;
          wr_state_n = WR_WRITING;
        end
      end
      WR_WRITING: begin
        if (w_elem[wsel_q][WIDTH-1]) begin
          wr_store = 1'b1;
          if (widx_q == wlast_q) begin
            wr_done    = 1'b1;
            wr_state_n = WR_IDLE;
          end
        end
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= WR_IDLE;
      wsel_q     <= '0;
      widx_q     <= '0;
      wlast_q    <= '0;
      w_busy_q   <= '0;
    end else begin
      wr_state_q <= wr_state_n;
      if (wr_start) begin
        wsel_q   <= wsel_n;
        widx_q   <= '0;
        wlast_q  <= IW'(len - 1'b1);
        w_busy_q <= NUM_WRITE_PORTS'(1) << wsel_n;
      end else if (wr_store) begin
        widx_q <= widx_q + IW'(1);
        if (wr_done) w_busy_q <= '0;
      end
    end
  end

  // NOTE: element storage has no reset; its contents are don't-care until
  // written, and only the valid flags need a defined reset value.
  always_ff @(posedge clk_i) begin
    if (wr_store) mem[widx_q] <= w_elem[wsel_q][DATA_WIDTH-1:0];
  end

  assign w_busy_o = w_busy_q;

`ifdef VREG_CHAIN_EN
  logic [MVL-1:0] vflag;
  logic           first_elem_q;

  // Flags are cleared on write start so chained readers wait for new data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vflag        <= '0;
      first_elem_q <= 1'b0;
    end else if (wr_start) begin
      vflag        <= '0;
      first_elem_q <= 1'b0;
    end else if (wr_store) begin
      vflag[widx_q] <= 1'b1;
      if (widx_q == '0) first_elem_q <= 1'b1;
    end
  end

  assign first_elem_o = first_elem_q;
`else
  assign first_elem_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read ports. A read of an element being written on the same edge sees the
  // old flag: availability comes from the registered flags, with no bypass.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
`ifdef VREG_CHAIN_EN
    assign rd_avail[p] = vflag[rd_idx[p]];
`else
    assign rd_avail[p] = 1'b1;
`endif

    vreg_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .MVL        (MVL)
    ) u_read_port (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (r_start_i[p]),
      .len_i   (len),
      .avail_i (rd_avail[p]),
      .elem_i  (mem[rd_idx[p]]),
      .idx_o   (rd_idx[p]),
      .data_o  (r_data_o[p*WIDTH +: WIDTH]),
      .busy_o  (r_busy_o[p])
    );
  end

endmodule
